// File: rtl/adc_audio_pkg.sv
// Shared definitions for the I2S ADC receiver.
// Register map, status/control bit positions and receive FSM states.
package adc_audio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_CLEAR   = 2'd3;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_SHIFT,
        ST_HOLD
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO for stereo sample pairs.
// Clear has priority over push; a full FIFO accepts a push only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    input  logic                     clear,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_i2s_rx.sv
// I2S ADC receiver with stereo-pair FIFO and Avalon-MM register file.
// Codec signals are synchronized into clk; sampling follows detected bclk rises.
module adc_i2s_rx
    import adc_audio_pkg::*;
#(
    parameter int SAMPLE_BITS = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bclk,
    input  logic        adclrc,
    input  logic        adcdat,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PAD = 16 - SAMPLE_BITS;

    logic [1:0] bclk_s;
    logic [1:0] lrc_s;
    logic [1:0] dat_s;
    logic       bclk_p;
    logic       lrc_p;
    logic       rise_q;
    logic       dat_q;
    logic       lrc_fall;
    logic       lrc_rise;
    logic       lrc_edge;

    rx_state_t              state;
    logic [4:0]             bit_cnt;
    logic [SAMPLE_BITS-1:0] shreg;
    logic [SAMPLE_BITS-1:0] next_word;
    logic [15:0]            word16;
    logic [15:0]            left_word;
    logic                   left_ok;
    logic                   chan_right;
    logic                   push_q;
    logic [31:0]            push_word;

    logic          enable;
    logic          irq_en;
    logic          overflow;
    logic          clear_fifo;
    logic          pop_req;
    logic [31:0]   pop_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [31:0]   status_word;
    logic          unused_wdata;

    assign unused_wdata = ^writedata[31:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_s <= '0;
            lrc_s  <= '0;
            dat_s  <= '0;
            bclk_p <= 1'b0;
            lrc_p  <= 1'b0;
            rise_q <= 1'b0;
            dat_q  <= 1'b0;
        end else begin
            bclk_s <= {bclk_s[0], bclk};
            lrc_s  <= {lrc_s[0], adclrc};
            dat_s  <= {dat_s[0], adcdat};
            bclk_p <= bclk_s[1];
            lrc_p  <= lrc_s[1];
            rise_q <= bclk_s[1] & ~bclk_p;
            dat_q  <= dat_s[1];
        end
    end

    assign lrc_fall  = lrc_p & ~lrc_s[1];
    assign lrc_rise  = ~lrc_p & lrc_s[1];
    assign lrc_edge  = lrc_fall | lrc_rise;
    assign next_word = {shreg[SAMPLE_BITS-2:0], dat_q};
    assign word16    = 16'(next_word) << PAD;

    // An edge outside IDLE always restarts at DELAY; a mid-sample edge
    // or a new left channel invalidates any captured left half.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            left_word  <= '0;
            left_ok    <= 1'b0;
            chan_right <= 1'b0;
            push_q     <= 1'b0;
            push_word  <= '0;
        end else begin
            push_q <= 1'b0;
            if (!enable) begin
                state   <= ST_IDLE;
                left_ok <= 1'b0;
            end else if (state != ST_IDLE && lrc_edge) begin
                state      <= ST_DELAY;
                chan_right <= lrc_rise;
                bit_cnt    <= '0;
                if (state == ST_SHIFT || lrc_fall) begin
                    left_ok <= 1'b0;
                end
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (lrc_fall) begin
                            state      <= ST_DELAY;
                            chan_right <= 1'b0;
                            bit_cnt    <= '0;
                            left_ok    <= 1'b0;
                        end
                    end
                    ST_DELAY: begin
                        if (rise_q) begin
                            state <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (rise_q) begin
                            shreg   <= next_word;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 5'(SAMPLE_BITS - 1)) begin
                                state <= ST_HOLD;
                                if (!chan_right) begin
                                    left_word <= word16;
                                    left_ok   <= 1'b1;
                                end else begin
                                    push_q    <= left_ok;
                                    push_word <= {left_word, word16};
                                    left_ok   <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_HOLD: begin
                    end
                endcase
            end
        end
    end

    assign clear_fifo = write && (address == ADDR_CLEAR) && writedata[0];
    assign pop_req    = read && (address == ADDR_DATA);

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_q),
        .push_data (push_word),
        .pop       (pop_req),
        .pop_data  (pop_data),
        .clear     (clear_fifo),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        status_word                          = '0;
        status_word[STAT_EMPTY]              = empty;
        status_word[STAT_FULL]               = full;
        status_word[STAT_OVERFLOW]           = overflow;
        status_word[STAT_COUNT_LSB +: 8]     = 8'(count);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            readdata <= '0;
        end else begin
            if (write && address == ADDR_CONTROL) begin
                enable <= writedata[CTRL_ENABLE];
                irq_en <= writedata[CTRL_IRQ_EN];
            end
            if (clear_fifo) begin
                overflow <= 1'b0;
            end else if (push_q && full && !(pop_req && !empty)) begin
                overflow <= 1'b1;
            end
            if (read) begin
                unique case (address)
                    ADDR_DATA:    readdata <= empty ? 32'd0 : pop_data;
                    ADDR_STATUS:  readdata <= status_word;
                    ADDR_CONTROL: readdata <= {30'd0, irq_en, enable};
                    ADDR_CLEAR:   readdata <= 32'd0;
                endcase
            end
        end
    end

    assign irq = irq_en & ~empty;

endmodule

// File: tb/tb_adc_i2s_rx.sv
// Scoreboard bench for adc_i2s_rx: reads queue expected values,
// a monitor compares readdata one cycle after each read strobe.
module tb_adc_i2s_rx;
    import adc_audio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bclk = 1'b0;
    logic        adclrc = 1'b1;
    logic        adcdat = 1'b0;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_q = 1'b0;

    adc_i2s_rx #(
        .SAMPLE_BITS (16),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bclk      (bclk),
        .adclrc    (adclrc),
        .adcdat    (adcdat),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_q <= read;

    always @(negedge clk) begin
        if (rd_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read: got %h expected none", readdata);
            end else begin
                check(name_q.pop_front(), readdata, exp_q.pop_front());
            end
        end
    end

    task automatic rd(input logic [1:0] a, input logic [31:0] e,
                      input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk);
        address = a;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a;
        writedata = d;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One channel slot: rise 1 is the I2S delay bit, rises 2..17 carry MSB first.
    task automatic half(input logic lr, input logic [15:0] s, input int slot);
        for (int i = 0; i < slot; i++) begin
            if (i == 0) adclrc = lr;
            adcdat = (i >= 1 && i <= 16) ? s[16 - i] : 1'b0;
            #40 bclk = 1'b1;
            #40 bclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r);
        half(1'b0, l, 18);
        half(1'b1, r, 18);
    endtask

    initial begin
        idle(3);
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        idle(4);
        rd(ADDR_STATUS, 32'h0000_0001, "reset_status");
        rd(ADDR_CONTROL, 32'h0, "reset_control");

        rd(ADDR_DATA, 32'h0, "empty_data_read");
        rd(ADDR_STATUS, 32'h0000_0001, "empty_after_read");

        wr(ADDR_CONTROL, 32'h1);
        frame(16'h1234, 16'hABCD);
        idle(10);
        rd(ADDR_STATUS, 32'h0000_0100, "one_frame_status");
        rd(ADDR_DATA, 32'h1234_ABCD, "one_frame_data");
        rd(ADDR_STATUS, 32'h0000_0001, "one_frame_empty");

        for (int k = 1; k <= 9; k++) begin
            frame(16'h1000 + 16'(k), 16'h2000 + 16'(k));
        end
        idle(10);
        rd(ADDR_STATUS, 32'h0000_0806, "overflow_status");
        for (int k = 1; k <= 8; k++) begin
            rd(ADDR_DATA, {16'h1000 + 16'(k), 16'h2000 + 16'(k)}, "fifo_order");
        end
        rd(ADDR_STATUS, 32'h0000_0005, "drained_sticky_ovf");
        wr(ADDR_CLEAR, 32'h1);
        rd(ADDR_STATUS, 32'h0000_0001, "clear_status");

        half(1'b0, 16'h5555, 8);
        half(1'b1, 16'h3333, 18);
        frame(16'h0F0F, 16'hF0F0);
        idle(10);
        rd(ADDR_STATUS, 32'h0000_0100, "abort_status");
        rd(ADDR_DATA, 32'h0F0F_F0F0, "abort_data");
        rd(ADDR_STATUS, 32'h0000_0001, "abort_empty");

        half(1'b0, 16'hAAAA, 18);
        wr(ADDR_CONTROL, 32'h0);
        wr(ADDR_CONTROL, 32'h1);
        half(1'b1, 16'hBBBB, 18);
        frame(16'h1111, 16'h2222);
        idle(10);
        rd(ADDR_STATUS, 32'h0000_0100, "disable_status");
        rd(ADDR_DATA, 32'h1111_2222, "disable_data");

        wr(ADDR_CONTROL, 32'h3);
        check("irq_idle_low", {31'd0, irq}, 32'd0);
        frame(16'h0001, 16'h0002);
        idle(10);
        check("irq_high", {31'd0, irq}, 32'd1);
        wr(ADDR_CLEAR, 32'h1);
        check("irq_after_clear", {31'd0, irq}, 32'd0);
        rd(ADDR_STATUS, 32'h0000_0001, "status_after_clear");
        rd(ADDR_CONTROL, 32'h0000_0003, "control_rb");

        frame(16'h0003, 16'h0004);
        idle(10);
        check("irq_before_reset", {31'd0, irq}, 32'd1);
        rd(ADDR_CONTROL, 32'h0000_0003, "control_before_reset");
        half(1'b0, 16'hFFFF, 6);
        #3 reset_n = 1'b0;
        #1;
        check("shift_reset_readdata", readdata, 32'd0);
        check("shift_reset_irq", {31'd0, irq}, 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(4);
        frame(16'h5A5A, 16'hA5A5);
        frame(16'h6B6B, 16'hB6B6);
        idle(10);
        rd(ADDR_STATUS, 32'h0000_0001, "disabled_no_entries");
        rd(ADDR_CONTROL, 32'h0, "control_after_reset");

        idle(4);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL pending_reads: got %0d left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_i2s_rx.md
ADC_I2S_RX -- requirements
Module: adc_i2s_rx

Interface
REQ-001 Parameter SAMPLE_BITS, default 16, bits per channel sample (8..16).
REQ-002 Parameter FIFO_DEPTH, default 8, stereo-pair FIFO entries (power of 2, 2..32).
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 bclk  input  1  codec bit clock, asynchronous to clk, at most clk/4.
REQ-006 adclrc  input  1  codec ADC L/R clock, asynchronous; low = left, high = right.
REQ-007 adcdat  input  1  codec ADC serial data, MSB first, asynchronous.
REQ-008 address  input  2  Avalon slave word address.
REQ-009 read  input  1  Avalon read strobe, one clk per access.
REQ-010 write  input  1  Avalon write strobe.
REQ-011 writedata  input  32  Avalon write data.
REQ-012 readdata  output  32  registered Avalon read data.
REQ-013 irq  output  1  level interrupt, high when FIFO not empty and IRQ enable set.

Function
REQ-014 bclk, adclrc and adcdat each pass through a 2-flop synchronizer; bit sampling occurs in the cycle after a synchronized bclk rising edge is detected.
REQ-015 Framing is I2S: the sample MSB is sampled on the second bclk rise after an adclrc edge (one-bit delay); the following SAMPLE_BITS-1 rises carry the remaining bits; extra bits until the next adclrc edge are ignored.
REQ-016 Receive FSM states: IDLE (wait for adclrc falling edge while enabled), DELAY (skip one bclk rise), SHIFT (capture SAMPLE_BITS bits), HOLD (wait for next adclrc edge).
REQ-017 A falling adclrc edge starts the left channel; a rising edge starts the right channel; an adclrc edge seen in SHIFT aborts the current frame and restarts at DELAY for the new channel, with no push.
REQ-018 On completion of a right sample following a completed left sample of the same frame, the pair {left[15:0], right[15:0]} (MSB-aligned, zero-padded below SAMPLE_BITS) is pushed into the FIFO.
REQ-019 Register map: addr 0 DATA (read pops one pair); addr 1 STATUS {[31:16] 0, [15:8] count, [2] overflow, [1] full, [0] empty}; addr 2 CONTROL (R/W) {[0] enable, [1] irq_en}; addr 3 CLEAR (write bit0 = 1 flushes FIFO and clears overflow; reads 0).
REQ-020 readdata is updated on the clk edge following read with the addressed value, giving one-cycle read latency; readdata holds its value when read is low.
REQ-021 A read of DATA when empty returns 0 and leaves pointers unchanged.
REQ-022 A push when full with no same-cycle pop drops the new pair and sets sticky overflow.
REQ-023 A simultaneous push and pop both take effect and leave count unchanged, including when full.
REQ-024 A CLEAR write coinciding with a push discards the push; the FIFO is empty next cycle.
REQ-025 Clearing enable returns the FSM to IDLE within one cycle and discards any partial pair; FIFO contents are retained.
REQ-026 Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Reset
REQ-027 On reset_n low: readdata = 0, irq = 0, FSM = IDLE, FIFO empty, count = 0, overflow = 0, enable = 0, irq_en = 0, and synchronizer flops = 0.
REQ-028 Reset deassertion requires no clk cycles of idle beyond the normal synchronizer settling.

Structure
REQ-029 A shared package adc_audio_pkg holds the register address constants, the STATUS bit positions, and the FSM state enumeration.
REQ-030 The FIFO is a sub-module sync_fifo (parameters WIDTH and DEPTH, with push, pop, clear, full, empty and count); the receive FSM and register file remain in adc_i2s_rx.

Verification
REQ-031 Enable = 1, then one I2S frame with L = 0x1234 and R = 0xABCD -> STATUS count = 1; DATA read returns 0x1234ABCD; a subsequent STATUS read shows empty = 1.
REQ-032 Nine frames with no reads (FIFO_DEPTH = 8) -> count = 8, full = 1, overflow = 1; eight DATA reads return frames 1..8 in order.
REQ-033 DATA read while empty -> readdata = 0 and count remains 0.
REQ-034 adclrc toggles mid-left-sample after 7 bits, followed by a full frame with L = 0x0F0F and R = 0xF0F0 -> exactly one entry, 0x0F0FF0F0.
REQ-035 irq_en = 1, one frame received -> irq = 1; CLEAR write -> irq = 0 next cycle and overflow = 0.
REQ-036 reset_n asserted during SHIFT -> all outputs are 0 immediately; after release and with enable = 0, incoming frames produce no FIFO entries.
